mem_byte_responder: RTL and testbench
=====================================

# mem_byte_responder

Multi-cycle responder for the pipeline's MEM-stage data-memory port. It accepts the same E/RW/Size/A/DI request the MEM stage drives today. It services the request one byte per beat over an internal 256x8 big-endian array. It returns DO plus a one-cycle ack, and holds a combinational busy high to stall the pipeline while the access is in flight. It replaces the zero-latency data RAM wherever realistic memory latency is needed, with the hazard unit using busy as an extra stall source.

## Interface
Parameters:
- ADDR_W, 8, byte-address width; array depth is 2**ADDR_W.
- WAIT_CYCLES, 0, idle cycles inserted before every byte beat (0..15).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- R  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- E  in  1  request valid; held by initiator until ack.
- RW  in  1  0 = read, 1 = write.
- Size  in  1  0 = byte, 1 = word.
- A  in  ADDR_W  byte address.
- DI  in  32  write data; byte uses DI[7:0].
- DO  out  32  read data, registered.
- busy  out  1  combinational: E & ~ack; stall request to pipeline.
- ack  out  1  one-cycle completion pulse.
- fault  out  1  misaligned-word flag; present only with alignment checking compiled in.

## Operation
- The FSM has four states: IDLE, WAIT, BEAT, ACK.
- IDLE: when E=1 on an edge, capture RW, Size, A, DI.
  - Load beat count: 1 for byte, 4 for word.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else BEAT.
- WAIT: decrement the wait counter. At 0 go to BEAT.
- BEAT: transfer one byte at address base+idx, idx = 0..3.
  - Write: store captured DI byte [31-8*idx -: 8] into mem[base+idx] (MSB at lowest address).
  - Read: shift mem[base+idx] into the assembly register.
  - If beats remain: reload the wait counter, go to WAIT or stay in BEAT.
  - On the last beat go to ACK.
- ACK: ack=1 for exactly one cycle.
  - On a read, DO loads: byte gives {24'b0, byte}; word gives the assembled value.
  - Then go unconditionally to IDLE. A request present during ACK is sampled next cycle in IDLE, so there is always a one-cycle bubble between requests.
- Word base address is A with bits [1:0] forced to 00. Byte base is A. No address wrap is possible.
- Writes never change DO. DO holds its last read value indefinitely.
- Changes on E, A, DI or RW after capture are ignored.
  - E dropped mid-access is a protocol violation; the access still completes and ack still pulses.
- The memory array has no reset. Its contents survive R; the bench preloads it hierarchically via mem.

## Timing
- Reset values: state = IDLE, DO = 0, ack = 0, fault = 0, counters = 0.
  - busy follows E immediately, because ack = 0.
- Let W = WAIT_CYCLES. The capture edge is cycle 0.
  - Byte access: ack high in cycle 1+(1+W).
  - Word access: ack high in cycle 1+4*(1+W).
- With W=0: byte ack in cycle 2, word ack in cycle 5.
- Reset mid-access: the FSM returns to IDLE at once and no ack is issued.
  - Any write bytes already stored remain in the array. Later bytes are not written.

## Configuration
- MEM_RESP_ALIGN_CHECK_EN defined:
  - A word request with A[1:0] != 00 goes from IDLE directly to ACK.
  - ack=1 and fault=1 in the same cycle. No array access; DO unchanged.
  - The fault port exists and is 0 otherwise.
- Not defined: A[1:0] is silently ignored for words, and the fault port is absent.

## Structure
- Shared defines package mem_resp_pkg:
  - state encodings S_IDLE, S_WAIT, S_BEAT, S_ACK.
  - RW_READ = 0, RW_WRITE = 1.
  - SIZE_BYTE = 0, SIZE_WORD = 1.
- One sub-module: mem_resp_beat_ctr, holding the wait counter and beat index. It provides beat_go and last_beat strobes to the FSM.

## Test plan
- Reset with E=1: DO=0, ack=0, busy=1, state IDLE. Release R: byte read starts next edge.
- W=0, preload mem[0x10..0x13] = 0xDE, 0xAD, 0xBE, 0xEF; word read A=0x10: ack in cycle 5, DO=0xDEADBEEF, busy low in ack cycle.
- W=2, byte write A=0x21 DI=0x000000A5, then byte read A=0x21: write ack in cycle 4, read DO=0x000000A5. Confirm mem[0x20] and mem[0x22] are unchanged.
- Word write A=0x40 DI=0x12345678, then a read with E held through ACK:
  - array holds 12, 34, 56, 78 at 0x40..0x43.
  - one bubble cycle, then DO=0x12345678.
- Word write A=0x40 DI=0xCAFEF00D, with R pulsed low after the 2nd beat: mem[0x40..0x41] = CA, FE; mem[0x42..0x43] keep old values; no ack.
- With MEM_RESP_ALIGN_CHECK_EN, word read A=0x42: ack and fault in cycle 1, DO unchanged. Without the macro, the same read returns the word at 0x40.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the MEM-stage byte-serial memory responder.
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN (misaligned-word fault path).
package mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BEAT = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Index of the final byte beat: a byte is one beat, a word is four.
  function automatic logic [1:0] last_idx(input logic size);
    return (size == SIZE_WORD) ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/mem_byte_responder_if.sv
// Request/response bundle between the MEM stage and the byte responder.
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN adds the fault signal.
interface mem_byte_responder_if #(
  parameter int ADDR_W = 8
);

  logic              E;
  logic              RW;
  logic              Size;
  logic [ADDR_W-1:0] A;
  logic [31:0]       DI;
  logic [31:0]       DO;
  logic              busy;
  logic              ack;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic              fault;

  modport master (output E, RW, Size, A, DI, input DO, busy, ack, fault);
  modport slave  (input E, RW, Size, A, DI, output DO, busy, ack, fault);
`else
  modport master (output E, RW, Size, A, DI, input DO, busy, ack);
  modport slave  (input E, RW, Size, A, DI, output DO, busy, ack);
`endif

endinterface

// File: rtl/mem_resp_beat_ctr.sv
// Wait-cycle counter and byte-beat index for the responder FSM.
// beat_go_o marks the last wait cycle; last_beat_o marks the final byte beat.
// Optional feature macro MEM_RESP_ALIGN_CHECK_EN does not affect this block.
module mem_resp_beat_ctr
  import mem_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       R,
  input  logic       start_i,
  input  logic       size_i,
  input  logic       in_wait_i,
  input  logic       in_beat_i,
  output logic [1:0] idx_o,
  output logic       beat_go_o,
  output logic       last_beat_o
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [3:0] wait_q;
  logic [1:0] idx_q;
  logic [1:0] last_q;

  // Load on request capture, count down while waiting, step the index per beat.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      wait_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
    end else if (start_i) begin
      wait_q <= WAIT_LD;
      idx_q  <= '0;
      last_q <= last_idx(size_i);
    end else if (in_wait_i) begin
      wait_q <= wait_q - 4'd1;
    end else if (in_beat_i) begin
      wait_q <= WAIT_LD;
      idx_q  <= idx_q + 2'd1;
    end
  end

  // The decrement that reaches zero is the last wait cycle.
  assign beat_go_o   = (wait_q == 4'd1);
  assign last_beat_o = (idx_q == last_q);
  assign idx_o       = idx_q;

endmodule

// File: rtl/mem_byte_responder.sv
// Multi-cycle big-endian data-memory responder for the MEM stage.
// Serves one byte per beat over a 2**ADDR_W x 8 array, optionally padding each
// beat with WAIT_CYCLES idle cycles, and pulses ack for one cycle at the end.
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN -- misaligned word requests
// complete immediately with fault=1 and touch neither the array nor DO.
module mem_byte_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input logic                  clk,
  input logic                  R,
  mem_byte_responder_if.slave  bus
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);

  state_e            state_q;
  logic              rw_q;
  logic              size_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       data_q;   // write bytes shift out MSB-first, read bytes shift in
  logic [31:0]       do_q;
  logic              ack_q;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic              fault_q;
`endif

  logic [7:0]        mem [DEPTH];

  logic [1:0]        idx;
  logic              beat_go;
  logic              last_beat;
  logic              start;
  logic              misaligned;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rd_byte;
  state_e            after_beat;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misaligned = (bus.Size == SIZE_WORD) && (bus.A[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign start      = (state_q == S_IDLE) && bus.E && !misaligned;
  assign addr       = base_q + ADDR_W'(idx);
  assign rd_byte    = mem[addr];
  assign after_beat = HAS_WAIT ? S_WAIT : S_BEAT;

  mem_resp_beat_ctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_beat_ctr (
    .clk         (clk),
    .R           (R),
    .start_i     (start),
    .size_i      (bus.Size),
    .in_wait_i   (state_q == S_WAIT),
    .in_beat_i   (state_q == S_BEAT),
    .idx_o       (idx),
    .beat_go_o   (beat_go),
    .last_beat_o (last_beat)
  );

  // Request FSM: capture, wait, transfer bytes, then a single-cycle ack.
  // NOTE: every register here uses <= so all of them see pre-edge values of
  // each other (data_q feeds do_q in the same edge it shifts).
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= S_IDLE;
      rw_q    <= RW_READ;
      size_q  <= SIZE_BYTE;
      base_q  <= '0;
      data_q  <= '0;
      do_q    <= '0;
      ack_q   <= 1'b0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.E) begin
            if (misaligned) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
`ifdef MEM_RESP_ALIGN_CHECK_EN
              fault_q <= 1'b1;
`endif
            end else begin
              rw_q    <= bus.RW;
              size_q  <= bus.Size;
              base_q  <= (bus.Size == SIZE_WORD) ? {bus.A[ADDR_W-1:2], 2'b00} : bus.A;
              // A byte write sends DI[7:0]; park it where the MSB-first shift starts.
              data_q  <= (bus.Size == SIZE_WORD) ? bus.DI : {bus.DI[7:0], 24'h0};
              state_q <= HAS_WAIT ? S_WAIT : S_BEAT;
            end
          end
        end
        S_WAIT: begin
          if (beat_go) state_q <= S_BEAT;
        end
        S_BEAT: begin
          data_q <= {data_q[23:0], (rw_q == RW_READ) ? rd_byte : 8'h00};
          if (last_beat) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            if (rw_q == RW_READ) begin
              do_q <= (size_q == SIZE_WORD) ? {data_q[23:0], rd_byte} : {24'h0, rd_byte};
            end
          end else begin
            state_q <= after_beat;
          end
        end
        S_ACK: begin
          ack_q   <= 1'b0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
          fault_q <= 1'b0;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte store on each write beat; bytes already stored survive a reset.
  // NOTE: the array is intentionally left out of reset -- contents must persist
  // across R, and a reset would turn the RAM into a huge flop bank.
  always_ff @(posedge clk) begin
    if (state_q == S_BEAT && rw_q == RW_WRITE) begin
      mem[addr] <= data_q[31:24];
    end
  end

  assign bus.DO   = do_q;
  assign bus.ack  = ack_q;
  assign bus.busy = bus.E & ~ack_q;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign bus.fault = fault_q;
`endif

endmodule

// File: tb/tb_mem_byte_responder.sv
// Directed bench for mem_byte_responder: one instance with no wait cycles and
// one with two wait cycles per beat, sharing clock and reset.
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN selects the fault expectations.
module tb_mem_byte_responder;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  logic R;

  always #5 clk = ~clk;

  mem_byte_responder_if #(.ADDR_W(8)) b0 ();
  mem_byte_responder_if #(.ADDR_W(8)) b2 ();

  mem_byte_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .R   (R),
    .bus (b0.slave)
  );

  mem_byte_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
    .clk (clk),
    .R   (R),
    .bus (b2.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive0(input logic e, input logic rw, input logic size,
                        input logic [7:0] a, input logic [31:0] di);
    b0.E = e; b0.RW = rw; b0.Size = size; b0.A = a; b0.DI = di;
  endtask

  task automatic drive2(input logic e, input logic rw, input logic size,
                        input logic [7:0] a, input logic [31:0] di);
    b2.E = e; b2.RW = rw; b2.Size = size; b2.A = a; b2.DI = di;
  endtask

  // Count edges (cycle numbers start at 'start') until ack is seen at a negedge.
  task automatic wait_ack0(input int start, output int lat, output logic [31:0] dout,
                           output logic bsy, output logic flt);
    lat = -1; dout = 'x; bsy = 1'bx; flt = 1'bx;
    for (int c = start; c <= 64 && lat < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (b0.ack === 1'b1) begin
        lat = c; dout = b0.DO; bsy = b0.busy;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        flt = b0.fault;
`else
        flt = 1'b0;
`endif
      end
    end
  endtask

  task automatic wait_ack2(input int start, output int lat, output logic [31:0] dout,
                           output logic bsy);
    lat = -1; dout = 'x; bsy = 1'bx;
    for (int c = start; c <= 64 && lat < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (b2.ack === 1'b1) begin
        lat = c; dout = b2.DO; bsy = b2.busy;
      end
    end
  endtask

  int          lat;
  int          acks;
  logic [31:0] dout;
  logic        bsy;
  logic        flt;

  initial begin
    R = 1'b0;
    drive0(1'b1, RW_READ, SIZE_BYTE, 8'h11, 32'h0);
    drive2(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    dut0.mem[8'h10] = 8'hDE; dut0.mem[8'h11] = 8'hAD;
    dut0.mem[8'h12] = 8'hBE; dut0.mem[8'h13] = 8'hEF;
    dut2.mem[8'h20] = 8'h11; dut2.mem[8'h21] = 8'h22;
    dut2.mem[8'h22] = 8'h33; dut2.mem[8'h23] = 8'h44;

    // Reset held with E=1.
    repeat (2) @(negedge clk);
    check("rst_do",    b0.DO, 32'h0);
    check("rst_ack",   32'(b0.ack), 32'h0);
    check("rst_busy",  32'(b0.busy), 32'h1);
    check("rst_state", 32'(dut0.state_q), 32'(S_IDLE));
`ifdef MEM_RESP_ALIGN_CHECK_EN
    check("rst_fault", 32'(b0.fault), 32'h0);
`endif

    // Release: byte read at 0x11 starts on the next edge.
    R = 1'b1;
    wait_ack0(1, lat, dout, bsy, flt);
    drive0(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    check("byte_rd_lat",  32'(lat), 32'd2);
    check("byte_rd_do",   dout, 32'h0000_00AD);
    check("byte_rd_busy", 32'(bsy), 32'h0);
    @(negedge clk);
    check("ack_one_cycle", 32'(b0.ack), 32'h0);

    // Word read at 0x10, no wait cycles.
    drive0(1'b1, RW_READ, SIZE_WORD, 8'h10, 32'h0);
    wait_ack0(1, lat, dout, bsy, flt);
    drive0(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    check("word_rd_lat",  32'(lat), 32'd5);
    check("word_rd_do",   dout, 32'hDEAD_BEEF);
    check("word_rd_busy", 32'(bsy), 32'h0);

    // W=2: byte write 0x21, neighbours untouched, DO unchanged.
    @(negedge clk);
    drive2(1'b1, RW_WRITE, SIZE_BYTE, 8'h21, 32'h0000_00A5);
    wait_ack2(1, lat, dout, bsy);
    drive2(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    check("w2_bwr_lat", 32'(lat), 32'd4);
    check("w2_bwr_do",  dout, 32'h0);
    check("w2_mem21",   32'(dut2.mem[8'h21]), 32'hA5);
    check("w2_mem20",   32'(dut2.mem[8'h20]), 32'h11);
    check("w2_mem22",   32'(dut2.mem[8'h22]), 32'h33);

    @(negedge clk);
    drive2(1'b1, RW_READ, SIZE_BYTE, 8'h21, 32'h0);
    wait_ack2(1, lat, dout, bsy);
    drive2(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    check("w2_brd_lat", 32'(lat), 32'd4);
    check("w2_brd_do",  dout, 32'h0000_00A5);

    // W=2 word read: wait counter reloads between beats.
    @(negedge clk);
    drive2(1'b1, RW_READ, SIZE_WORD, 8'h20, 32'h0);
    wait_ack2(1, lat, dout, bsy);
    drive2(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    check("w2_wrd_lat", 32'(lat), 32'd13);
    check("w2_wrd_do",  dout, 32'h11A5_3344);

    // E dropped right after capture: access still completes.
    @(negedge clk);
    drive2(1'b1, RW_READ, SIZE_BYTE, 8'h23, 32'h0);
    @(negedge clk);
    drive2(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    wait_ack2(2, lat, dout, bsy);
    check("w2_edrop_lat", 32'(lat), 32'd4);
    check("w2_edrop_do",  dout, 32'h0000_0044);

    // Word write 0x40 with E held through ACK, then back-to-back word read.
    @(negedge clk);
    drive0(1'b1, RW_WRITE, SIZE_WORD, 8'h40, 32'h1234_5678);
    wait_ack0(1, lat, dout, bsy, flt);
    drive0(1'b1, RW_READ, SIZE_WORD, 8'h40, 32'h0);
    check("wwr_lat", 32'(lat), 32'd5);
    check("wwr_do",  dout, 32'hDEAD_BEEF);
    @(negedge clk);
    check("bubble_ack",   32'(b0.ack), 32'h0);
    check("bubble_busy",  32'(b0.busy), 32'h1);
    check("bubble_state", 32'(dut0.state_q), 32'(S_IDLE));
    check("wwr_mem", {dut0.mem[8'h40], dut0.mem[8'h41], dut0.mem[8'h42], dut0.mem[8'h43]},
          32'h1234_5678);
    wait_ack0(1, lat, dout, bsy, flt);
    drive0(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    check("b2b_rd_lat", 32'(lat), 32'd5);
    check("b2b_rd_do",  dout, 32'h1234_5678);

    // Word write 0xCAFEF00D aborted by reset after the second beat.
    @(negedge clk);
    drive0(1'b1, RW_WRITE, SIZE_WORD, 8'h40, 32'hCAFE_F00D);
    acks = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (b0.ack === 1'b1) acks++;
    end
    R = 1'b0;
    drive0(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    @(negedge clk);
    check("abort_state", 32'(dut0.state_q), 32'(S_IDLE));
    check("abort_do",    b0.DO, 32'h0);
    R = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (b0.ack === 1'b1) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'h0);
    check("abort_mem", {dut0.mem[8'h40], dut0.mem[8'h41], dut0.mem[8'h42], dut0.mem[8'h43]},
          32'hCAFE_5678);

    // Byte read to set a known DO, then a misaligned word read at 0x42.
    drive0(1'b1, RW_READ, SIZE_BYTE, 8'h41, 32'h0);
    wait_ack0(1, lat, dout, bsy, flt);
    drive0(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
    check("pre_mis_lat", 32'(lat), 32'd2);
    check("pre_mis_do",  dout, 32'h0000_00FE);

    @(negedge clk);
    drive0(1'b1, RW_READ, SIZE_WORD, 8'h42, 32'h0);
    wait_ack0(1, lat, dout, bsy, flt);
    drive0(1'b0, RW_READ, SIZE_BYTE, 8'h00, 32'h0);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    check("mis_lat",   32'(lat), 32'd1);
    check("mis_fault", 32'(flt), 32'h1);
    check("mis_do",    dout, 32'h0000_00FE);
    @(negedge clk);
    check("mis_fault_clr", 32'(b0.fault), 32'h0);
`else
    check("mis_lat", 32'(lat), 32'd5);
    check("mis_do",  dout, 32'hCAFE_5678);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
